// File: rtl/scheduler_pkg.sv
// Shared types and default sizing for the timer scheduler.
package scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned COUNTSIZE_DEF = 10000;

endpackage

// File: rtl/flexcounter_if.sv
// Control/status bundle between the scheduler and its shared counter.
interface flexcounter_if #(
  parameter int unsigned COUNTSIZE = 10000
);
  localparam int unsigned W = $clog2(COUNTSIZE);

  logic         enableCounter;
  logic [W-1:0] maxCount;
  logic         strobe;

  modport counter (input enableCounter, input maxCount, output strobe);
  modport ctrl    (output enableCounter, output maxCount, input strobe);
endinterface

// File: rtl/flexcounter.sv
// Free-running counter: cleared while disabled, pulses strobe each time it
// completes maxCount enabled cycles.
module flexcounter #(
  parameter int unsigned COUNTSIZE = 10000
) (
  input logic             clk,
  input logic             nRST,
  flexcounter_if.counter  cif
);
  localparam int unsigned W = $clog2(COUNTSIZE);

  logic [W-1:0] cnt_q;
  logic         strobe_q;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else if (!cif.enableCounter) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else if ((cnt_q + W'(1)) == cif.maxCount) begin
      cnt_q    <= '0;
      strobe_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_q + W'(1);
      strobe_q <= 1'b0;
    end
  end

  assign cif.strobe = strobe_q;

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one flexcounter among NREQ timer requesters.
module timer_scheduler
  import scheduler_pkg::*;
#(
  parameter int unsigned NREQ       = NREQ_DEF,
  parameter int unsigned COUNTSIZE  = COUNTSIZE_DEF,
  parameter int unsigned COUNTWIDTH = $clog2(COUNTSIZE)
) (
  input  logic                                clk,
  input  logic                                nRST,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ-1:0][COUNTWIDTH-1:0]     req_count,
  output logic [NREQ-1:0]                     done,
  output logic                                busy,
  output logic [$clog2(NREQ)-1:0]             grant_id,
  output logic                                grant_valid
);
  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CIFW = $clog2(COUNTSIZE);

  state_e                state_q;
  logic [IDW-1:0]        grant_q;
  logic [IDW-1:0]        last_q;
  logic [COUNTWIDTH-1:0] count_q;
  logic [NREQ-1:0]       done_q;
  logic                  act_q;

  logic [IDW-1:0]        win_c;
  logic [IDW-1:0]        idx_c;
  logic                  any_c;

  flexcounter_if #(.COUNTSIZE(COUNTSIZE)) cnt_if ();

  flexcounter #(.COUNTSIZE(COUNTSIZE)) u_cnt (
    .clk  (clk),
    .nRST (nRST),
    .cif  (cnt_if.counter)
  );

  assign cnt_if.enableCounter = (state_q == RUN);
  assign cnt_if.maxCount      = CIFW'(count_q);

  // First pending requester after the last owner, wrapping at NREQ.
  always_comb begin
    win_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = IDW'((32'(last_q) + k) % NREQ);
      if (!any_c && req[idx_c]) begin
        any_c = 1'b1;
        win_c = idx_c;
      end
    end
  end

  // Owner dropping req in LOAD/RUN aborts and takes priority over strobe.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      count_q <= '0;
      done_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_c) begin
            grant_q <= win_c;
            count_q <= req_count[win_c];
            act_q   <= 1'b1;
            if (req_count[win_c] != '0) begin
              state_q <= LOAD;
            end else begin
              state_q <= DONE;
              done_q  <= NREQ'(1) << win_c;
            end
          end
        end
        LOAD: begin
          if (!req[grant_q]) begin
            state_q <= IDLE;
            last_q  <= grant_q;
            act_q   <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!req[grant_q]) begin
            state_q <= IDLE;
            last_q  <= grant_q;
            act_q   <= 1'b0;
          end else if (cnt_if.strobe) begin
            state_q <= DONE;
            done_q  <= NREQ'(1) << grant_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          last_q  <= grant_q;
          act_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign busy        = act_q;
  assign grant_valid = act_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed-vector bench for timer_scheduler with hand-computed expectations.
module tb_timer_scheduler;
  import scheduler_pkg::*;

  logic             clk;
  logic             nRST;
  logic [3:0]       req;
  logic [3:0][13:0] req_count;
  logic [3:0]       done;
  logic             busy;
  logic [1:0]       grant_id;
  logic             grant_valid;

  int n_vec;
  int n_err;

  timer_scheduler dut (
    .clk         (clk),
    .nRST        (nRST),
    .req         (req),
    .req_count   (req_count),
    .done        (done),
    .busy        (busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the next done pulse; returns 0 on timeout.
  task automatic wait_done(output logic [3:0] d);
    d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != 4'b0) begin
        d = done;
        break;
      end
    end
  endtask

  logic [3:0] d;

  initial begin
    n_vec = 0;
    n_err = 0;
    clk = 1'b0;
    nRST = 1'b1;
    req = '0;
    req_count = '0;
    tick(2);

    // Reset values
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gv", 32'(grant_valid), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_en", 32'(dut.cnt_if.enableCounter), 32'h0);
    chk("rst_max", 32'(dut.cnt_if.maxCount), 32'h0);
    chk("rst_last", 32'(dut.last_q), 32'd3);
    nRST = 1'b0;
    tick(1);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Single request, count 3
    req = 4'b0001;
    req_count[0] = 14'd3;
    tick(1);
    chk("s_c1_state", 32'(dut.state_q), 32'(LOAD));
    chk("s_c1_busy", 32'(busy), 32'h1);
    chk("s_c1_gv", 32'(grant_valid), 32'h1);
    chk("s_c1_en", 32'(dut.cnt_if.enableCounter), 32'h0);
    tick(1);
    chk("s_c2_state", 32'(dut.state_q), 32'(RUN));
    chk("s_c2_en", 32'(dut.cnt_if.enableCounter), 32'h1);
    chk("s_c2_max", 32'(dut.cnt_if.maxCount), 32'd3);
    tick(3);
    chk("s_c5_strobe", 32'(dut.cnt_if.strobe), 32'h1);
    chk("s_c5_done", 32'(done), 32'h0);
    tick(1);
    chk("s_c6_done", 32'(done), 32'b0001);
    chk("s_c6_state", 32'(dut.state_q), 32'(DONE));
    req = 4'b0000;
    tick(1);
    chk("s_c7_done", 32'(done), 32'h0);
    chk("s_c7_busy", 32'(busy), 32'h0);

    // Zero count on requester 2
    req = 4'b0100;
    req_count[2] = 14'd0;
    chk("z_c0_en", 32'(dut.cnt_if.enableCounter), 32'h0);
    tick(1);
    chk("z_c1_done", 32'(done), 32'b0100);
    chk("z_c1_gid", 32'(grant_id), 32'd2);
    chk("z_c1_en", 32'(dut.cnt_if.enableCounter), 32'h0);
    req = 4'b0000;
    tick(1);
    chk("z_c2_done", 32'(done), 32'h0);
    chk("z_c2_en", 32'(dut.cnt_if.enableCounter), 32'h0);

    // Fairness from a fresh reset
    nRST = 1'b1;
    tick(1);
    nRST = 1'b0;
    req_count = {14'd2, 14'd2, 14'd2, 14'd2};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(d);
      chk("fair_done", 32'(d), 32'(4'b0001 << k));
      chk("fair_gid", 32'(grant_id), 32'(k));
      req[k] = 1'b0;
    end
    req = 4'b1001;
    wait_done(d);
    chk("rr_first", 32'(d), 32'b0001);
    req[0] = 1'b0;
    wait_done(d);
    chk("rr_second", 32'(d), 32'b1000);
    req[3] = 1'b0;
    tick(1);

    // Abort of requester 1 with requester 3 pending
    req_count[1] = 14'd50;
    req_count[3] = 14'd2;
    req = 4'b1010;
    tick(2);
    chk("a_gid", 32'(grant_id), 32'd1);
    tick(9);
    chk("a_c11_state", 32'(dut.state_q), 32'(RUN));
    req[1] = 1'b0;
    tick(1);
    chk("a_c12_state", 32'(dut.state_q), 32'(IDLE));
    chk("a_c12_done", 32'(done), 32'h0);
    chk("a_c12_busy", 32'(busy), 32'h0);
    tick(1);
    chk("a_c13_state", 32'(dut.state_q), 32'(LOAD));
    chk("a_c13_gid", 32'(grant_id), 32'd3);
    wait_done(d);
    chk("a_next_done", 32'(d), 32'b1000);
    req = 4'b0000;
    tick(1);

    // Reset in the middle of a run
    req = 4'b0100;
    req_count[2] = 14'd20;
    tick(4);
    chk("r_state", 32'(dut.state_q), 32'(RUN));
    nRST = 1'b1;
    req = 4'b0001;
    req_count[0] = 14'd1;
    #1;
    chk("r_done", 32'(done), 32'h0);
    chk("r_busy", 32'(busy), 32'h0);
    chk("r_gv", 32'(grant_valid), 32'h0);
    chk("r_gid", 32'(grant_id), 32'h0);
    chk("r_en", 32'(dut.cnt_if.enableCounter), 32'h0);
    chk("r_state_idle", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    nRST = 1'b0;
    tick(1);
    chk("r_c1_state", 32'(dut.state_q), 32'(LOAD));
    chk("r_c1_gid", 32'(grant_id), 32'd0);
    tick(2);
    chk("r_c3_done", 32'(done), 32'h0);
    tick(1);
    chk("r_c4_done", 32'(done), 32'b0001);
    req = 4'b0000;
    tick(1);

    // Strobe and abort in the same cycle
    req = 4'b0010;
    req_count[1] = 14'd3;
    tick(5);
    chk("c_c5_strobe", 32'(dut.cnt_if.strobe), 32'h1);
    chk("c_c5_state", 32'(dut.state_q), 32'(RUN));
    req = 4'b0000;
    tick(1);
    chk("c_c6_done", 32'(done), 32'h0);
    chk("c_c6_state", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    chk("c_c7_done", 32'(done), 32'h0);
    chk("c_c7_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
